// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: default sizes,
// bank-state encoding and the bit-reversal helper.
package fft_pkg;

    localparam int unsigned N_LOG2_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT     = 16;
    localparam int unsigned IDX_MAX        = 16;
    localparam int unsigned IDX_AW         = $clog2(IDX_MAX);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Reverses the low n_log2 bits of idx; bits above n_log2 come back as zero.
    function automatic logic [IDX_MAX-1:0] bitrev(input logic [IDX_MAX-1:0] idx,
                                                  input int unsigned n_log2);
        logic [IDX_MAX-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < n_log2; b++) begin
            r[IDX_AW'(b)] = idx[IDX_AW'(n_log2 - 1 - b)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read data register holds its value while rd_en is low.
module fft_reorder_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes a bit-reversed FFT output stream and
// re-emits each frame in natural order on a valid/ready stream.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2 = N_LOG2_DEFAULT,
    parameter int unsigned DW     = DW_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_r,
    input  logic [DW-1:0]     in_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_r,
    output logic [DW-1:0]     out_i,
    output logic [N_LOG2-1:0] out_idx,
    output logic              out_last
);

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    bank_state_t       bank_state [2];
    logic              wbank;
    logic              rbank;
    logic [N_LOG2-1:0] wcnt;
    logic [N_LOG2-1:0] rcnt;
    logic [N_LOG2-1:0] wr_rev;

    logic              s1_valid;
    logic              s1_last;
    logic [N_LOG2-1:0] s1_idx;
    logic [2*DW-1:0]   rd_data;

    logic              wr_fire;
    logic              can_fetch;
    logic              rd_issue;
    logic              out_adv;

    always_comb begin
        in_ready  = (bank_state[wbank] == BANK_EMPTY) || (bank_state[wbank] == BANK_FILLING);
        wr_fire   = in_valid && in_ready;
        wr_rev    = N_LOG2'(bitrev(IDX_MAX'(wcnt), N_LOG2));
        out_adv   = !out_valid || out_ready;
        can_fetch = (bank_state[rbank] == BANK_FULL) || (bank_state[rbank] == BANK_DRAINING);
        rd_issue  = can_fetch && (!s1_valid || out_adv);
    end

    fft_reorder_ram #(
        .ADDR_W (N_LOG2 + 1),
        .DATA_W (2 * DW)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (wr_fire),
        .wr_addr ({wbank, wr_rev}),
        .wr_data ({in_r, in_i}),
        .rd_en   (rd_issue),
        .rd_addr ({rbank, rcnt}),
        .rd_data (rd_data)
    );

    // A bank is released once its last word has left the RAM; the remaining
    // words live in the pipeline registers, so the writer may refill it at
    // once and back-to-back frames never stall the input.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
        end else begin
            if (wr_fire) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST_IDX) begin
                    bank_state[wbank] <= BANK_FULL;
                    wbank             <= ~wbank;
                end else if (bank_state[wbank] == BANK_EMPTY) begin
                    bank_state[wbank] <= BANK_FILLING;
                end
            end
            if (rd_issue) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == LAST_IDX) begin
                    bank_state[rbank] <= BANK_EMPTY;
                    rbank             <= ~rbank;
                end else if (bank_state[rbank] == BANK_FULL) begin
                    bank_state[rbank] <= BANK_DRAINING;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (rd_issue) begin
                s1_valid <= 1'b1;
                s1_idx   <= rcnt;
                s1_last  <= (rcnt == LAST_IDX);
            end else if (out_adv) begin
                s1_valid <= 1'b0;
            end
            if (out_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_r    <= rd_data[2*DW-1:DW];
                    out_i    <= rd_data[DW-1:0];
                    out_idx  <= s1_idx;
                    out_last <= s1_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: randomized streams scored
// against a frame-level bit-reversal reference model.
module tb_fft_bitrev_reorder;

    localparam int unsigned NL = 8;
    localparam int unsigned N  = 256;
    localparam int unsigned W  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_r      = '0;
    logic [W-1:0]  in_i      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic [W-1:0]  out_r;
    logic [W-1:0]  out_i;
    logic [NL-1:0] out_idx;

    logic          s_in_valid  = 1'b0;
    logic          s_out_ready = 1'b0;
    logic [W-1:0]  s_in_r      = '0;
    logic [W-1:0]  s_in_i      = '0;
    logic          s_in_ready;
    logic          s_out_valid;
    logic          s_out_last;
    logic [W-1:0]  s_out_r;
    logic [W-1:0]  s_out_i;
    logic [2:0]    s_out_idx;

    fft_bitrev_reorder #(.N_LOG2(8), .DW(16)) dut (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
        .out_idx(out_idx), .out_last(out_last)
    );

    fft_bitrev_reorder #(.N_LOG2(3), .DW(16)) dut_small (
        .CLK(clk), .RST_N(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_r(s_in_r), .in_i(s_in_i),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_r(s_out_r), .out_i(s_out_i),
        .out_idx(s_out_idx), .out_last(s_out_last)
    );

    typedef struct packed {
        logic [W-1:0]  r;
        logic [W-1:0]  i;
        logic [NL-1:0] idx;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [2*W-1:0] frame_buf [N];
    int unsigned   wslot = 0;
    int            checks = 0;
    int            failures = 0;

    function automatic int unsigned ref_bitrev(input int unsigned x, input int unsigned bits);
        int unsigned v;
        int unsigned r;
        v = x;
        r = 0;
        for (int unsigned b = 0; b < bits; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    // Frame slot k holds X[bitrev(k)], so natural output m is slot bitrev(m).
    task automatic model_accept(input logic [W-1:0] r, input logic [W-1:0] i);
        exp_t           e;
        logic [2*W-1:0] w;
        frame_buf[wslot] = {r, i};
        wslot++;
        if (wslot == N) begin
            for (int unsigned m = 0; m < N; m++) begin
                w      = frame_buf[ref_bitrev(m, NL)];
                e.r    = w[2*W-1:W];
                e.i    = w[W-1:0];
                e.idx  = NL'(m);
                e.last = (m == N - 1);
                exp_q.push_back(e);
            end
            wslot = 0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        wslot = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_r, out_i, out_idx, out_last} !== {1'b1, 1'b0, 16'h0, 16'h0, 8'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b r=%h i=%h idx=%0d last=%b want rdy=1 vld=0 r=0 i=0 idx=0 last=0",
                     in_ready, out_valid, out_r, out_i, out_idx, out_last);
        end
        checks++;
        if ({s_in_ready, s_out_valid, s_out_r, s_out_idx, s_out_last} !== {1'b1, 1'b0, 16'h0, 3'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state_small: got rdy=%b vld=%b r=%h idx=%0d last=%b want 1 0 0 0 0",
                     s_in_ready, s_out_valid, s_out_r, s_out_idx, s_out_last);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_natural();
        int unsigned  k = 0, m = 0, cyc = 0, acc_cyc = 0, first_cyc = 0;
        bit           seen = 0;
        logic [W-1:0] er, ei;
        apply_reset();
        out_ready = 1'b1;
        while (m < N && cyc < 2000) begin
            @(negedge clk);
            in_valid = (k < N);
            in_r     = 16'(k);
            in_i     = -in_r;
            #1;
            if (out_valid && !seen) begin
                seen      = 1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                er = 16'(ref_bitrev(m, NL));
                ei = -er;
                checks++;
                if (out_r !== er || out_i !== ei || out_idx !== NL'(m) || out_last !== (m == N - 1)) begin
                    failures++;
                    $display("FAIL natural_data: m=%0d got r=%h i=%h idx=%0d last=%b want r=%h i=%h idx=%0d last=%b",
                             m, out_r, out_i, out_idx, out_last, er, ei, m, (m == N - 1));
                end
                m++;
            end
            if (in_valid && in_ready) begin
                if (k == N - 1) acc_cyc = cyc;
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (m != N) begin
            failures++;
            $display("FAIL natural_count: got %0d outputs want %0d", m, N);
        end
        checks++;
        if (first_cyc - acc_cyc != 3) begin
            failures++;
            $display("FAIL natural_latency: got %0d sample cycles want 3", first_cyc - acc_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned  k = 0, n = 0, cyc = 0, drops = 0, gaps = 0;
        bit           seen = 0;
        exp_t         e;
        logic [W-1:0] er;
        apply_reset();
        out_ready = 1'b1;
        while (n < 4 * N && cyc < 3000) begin
            @(negedge clk);
            in_valid = (k < 4 * N);
            in_r     = 16'(k);
            in_i     = 16'($urandom);
            #1;
            if (in_valid && !in_ready) drops++;
            if (out_valid) seen = 1;
            else if (seen) gaps++;
            if (out_valid && out_ready) begin
                checks++;
                er = 16'(ref_bitrev(n % N, NL) + N * (n / N));
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_data: unexpected output idx=%0d", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_r, out_i, out_idx, out_last} !== e || out_r !== er) begin
                        failures++;
                        $display("FAIL b2b_data: n=%0d got r=%h i=%h idx=%0d last=%b want r=%h i=%h idx=%0d last=%b",
                                 n, out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, e.last);
                    end
                end
                n++;
            end
            if (in_valid && in_ready) begin
                model_accept(in_r, in_i);
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != 4 * N) begin
            failures++;
            $display("FAIL b2b_count: got %0d outputs want %0d", n, 4 * N);
        end
        checks++;
        if (drops != 0) begin
            failures++;
            $display("FAIL b2b_in_ready: got %0d stalled cycles want 0", drops);
        end
        checks++;
        if (gaps != 0) begin
            failures++;
            $display("FAIL b2b_gaps: got %0d output bubbles want 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int unsigned   k = 0, n = 0, cyc = 0, unstable = 0;
        bit            snap = 0;
        logic [W-1:0]  hr, hi;
        logic [NL-1:0] hidx;
        exp_t          e;
        apply_reset();
        out_ready = 1'b0;
        while (n < 3 * N && cyc < 4000) begin
            @(negedge clk);
            if (cyc == 600) begin
                checks++;
                if (k != 2 * N || in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready: got accepted=%0d in_ready=%b want accepted=%0d in_ready=0", k, in_ready, 2 * N);
                end
                checks++;
                if (!snap || out_valid !== 1'b1 || hidx !== 8'd0 || unstable != 0) begin
                    failures++;
                    $display("FAIL bp_hold: got seen=%b vld=%b idx=%0d unstable=%0d want seen=1 vld=1 idx=0 unstable=0",
                             snap, out_valid, hidx, unstable);
                end
                out_ready = 1'b1;
            end
            in_valid = (k < 3 * N);
            in_r     = 16'(k % N);
            in_i     = -in_r;
            #1;
            if (cyc < 600 && out_valid) begin
                if (!snap) begin
                    snap = 1;
                    hr   = out_r;
                    hi   = out_i;
                    hidx = out_idx;
                end else if (out_r !== hr || out_i !== hi || out_idx !== hidx) begin
                    unstable++;
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_data: unexpected output idx=%0d", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_r, out_i, out_idx, out_last} !== e) begin
                        failures++;
                        $display("FAIL bp_data: n=%0d got r=%h i=%h idx=%0d last=%b want r=%h i=%h idx=%0d last=%b",
                                 n, out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, e.last);
                    end
                end
                n++;
            end
            if (in_valid && in_ready) begin
                model_accept(in_r, in_i);
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != 3 * N || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got %0d outputs, %0d left want %0d outputs, 0 left", n, exp_q.size(), 3 * N);
        end
    endtask

    task automatic test_random();
        int unsigned k = 0, n = 0, cyc = 0, lasts = 0;
        bit          pending = 0;
        exp_t        e;
        apply_reset();
        while (n < 3 * N && cyc < 8000) begin
            @(negedge clk);
            if (!pending) begin
                in_valid = (k < 3 * N) && ($urandom_range(0, 3) != 0);
                in_r     = 16'($urandom);
                in_i     = 16'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (out_last) lasts++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_data: unexpected output idx=%0d", out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_r, out_i, out_idx, out_last} !== e) begin
                        failures++;
                        $display("FAIL rand_data: n=%0d got r=%h i=%h idx=%0d last=%b want r=%h i=%h idx=%0d last=%b",
                                 n, out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, e.last);
                    end
                end
                n++;
            end
            pending = in_valid && !in_ready;
            if (in_valid && in_ready) begin
                model_accept(in_r, in_i);
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != 3 * N || lasts != 3) begin
            failures++;
            $display("FAIL rand_count: got outputs=%0d lasts=%0d want outputs=%0d lasts=3", n, lasts, 3 * N);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned k = 0, n = 0, cyc = 0, extra = 0;
        exp_t        e;
        apply_reset();
        out_ready = 1'b1;
        while (k < 2 * N + 101 && cyc < 2000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_r     = 16'($urandom);
            in_i     = 16'($urandom);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if ({out_r, out_i, out_idx, out_last} !== e) begin
                    failures++;
                    $display("FAIL rstmid_pre: got r=%h idx=%0d want r=%h idx=%0d", out_r, out_idx, e.r, e.idx);
                end
            end
            if (in_ready) begin
                model_accept(in_r, in_i);
                k++;
            end
            cyc++;
        end
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_state: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        wslot = 0;
        k     = 0;
        cyc   = 0;
        while (cyc < 600) begin
            @(negedge clk);
            in_valid = (k < N);
            in_r     = 16'($urandom);
            in_i     = 16'($urandom);
            #1;
            if (out_valid && out_ready) begin
                if (n == 0) begin
                    checks++;
                    if (out_idx !== 8'd0) begin
                        failures++;
                        $display("FAIL rstmid_first_idx: got %0d want 0", out_idx);
                    end
                end
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    checks++;
                    e = exp_q.pop_front();
                    if ({out_r, out_i, out_idx, out_last} !== e) begin
                        failures++;
                        $display("FAIL rstmid_data: n=%0d got r=%h i=%h idx=%0d last=%b want r=%h i=%h idx=%0d last=%b",
                                 n, out_r, out_i, out_idx, out_last, e.r, e.i, e.idx, e.last);
                    end
                end
                n++;
            end
            if (in_valid && in_ready) begin
                model_accept(in_r, in_i);
                k++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != N || extra != 0) begin
            failures++;
            $display("FAIL rstmid_count: got outputs=%0d extra=%0d want outputs=%0d extra=0", n, extra, N);
        end
    endtask

    task automatic test_small();
        int unsigned  k = 0, m = 0, cyc = 0, acc_cyc = 0, first_cyc = 0;
        bit           seen = 0;
        int unsigned  want [8];
        logic [W-1:0] er;
        want = '{0, 4, 2, 6, 1, 5, 3, 7};
        apply_reset();
        s_out_ready = 1'b1;
        while (m < 8 && cyc < 100) begin
            @(negedge clk);
            s_in_valid = (k < 8);
            s_in_r     = 16'(k);
            s_in_i     = 16'(k) ^ 16'hFFFF;
            #1;
            if (s_out_valid && !seen) begin
                seen      = 1;
                first_cyc = cyc;
            end
            if (s_out_valid && s_out_ready) begin
                er = 16'(want[m]);
                checks++;
                if (s_out_r !== er || s_out_i !== (er ^ 16'hFFFF) || s_out_idx !== 3'(m) || s_out_last !== (m == 7)) begin
                    failures++;
                    $display("FAIL small_data: m=%0d got r=%h i=%h idx=%0d last=%b want r=%h idx=%0d last=%b",
                             m, s_out_r, s_out_i, s_out_idx, s_out_last, er, m, (m == 7));
                end
                m++;
            end
            if (s_in_valid && s_in_ready) begin
                if (k == 7) acc_cyc = cyc;
                k++;
            end
            cyc++;
        end
        s_in_valid = 1'b0;
        checks++;
        if (m != 8 || first_cyc - acc_cyc != 3) begin
            failures++;
            $display("FAIL small_latency: got outputs=%0d latency=%0d want outputs=8 latency=3", m, first_cyc - acc_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
